// File: rtl/seq_detect_pkg.sv
// Shared types, defaults and helpers for the parametrised serial-pattern detector.
package seq_detect_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int VEC_W       = 32;

    typedef enum logic {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } det_state_e;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Keeps bits [len-1:0] of v and zeroes the rest; callers zero-extend to VEC_W.
    function automatic logic [VEC_W-1:0] mask_low(input logic [VEC_W-1:0] v, input int len);
        logic [VEC_W-1:0] m;
        m = '0;
        for (int i = 0; i < VEC_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return v & m;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detect_param.sv
// Mealy serial-pattern detector with run-time pattern/length/overlap and a match counter.
// States: ST_UNCFG = latched config invalid (cfg_err=1, y never fires) | ST_RUN = detecting.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = len_width(MAX_LEN),
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    det_state_e         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;

    logic [MAX_LEN-1:0] window;
    logic               pat_hit;
    logic               fill_ok;
    logic               cfg_bad;
    logic               match;

    always_comb begin
        window  = {hist_q, din};
        pat_hit = (mask_low(VEC_W'(window), int'(len_q)) == mask_low(VEC_W'(pat_q), int'(len_q)));
        fill_ok = (int'(fill_q) >= (int'(len_q) - 1));
        cfg_bad = (cfg_len == '0) || (int'(cfg_len) > MAX_LEN);
        match   = din_valid && !cfg_load && reset && (state_q == ST_RUN) && fill_ok && pat_hit;
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (cfg_load) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = cfg_bad ? ST_UNCFG : ST_RUN;
        end else if (din_valid) begin
            // Non-overlapping mode restarts from an empty history after each hit.
            if (match && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[MAX_LEN-2:0];
                if (int'(fill_q) < (MAX_LEN - 1)) fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_UNCFG;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .count (match_count)
    );

    assign y       = match;
    assign cfg_err = (state_q == ST_UNCFG);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed table-driven bench for seq_detect_param (default counter and a 2-bit counter copy).
module tb_seq_detect_param;
    import seq_detect_pkg::*;

    localparam int ML = 8;
    localparam int LW = len_width(ML);

    logic          clk = 1'b0;
    logic          reset, din, din_valid, cfg_load, cfg_overlap;
    logic [ML-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          y8, y2, err8, err2;
    logic [7:0]    cnt8;
    logic [1:0]    cnt2;

    always #5 clk = ~clk;

    seq_detect_param #(.MAX_LEN(ML), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .y(y8), .match_count(cnt8), .cfg_err(err8));

    seq_detect_param #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .y(y2), .match_count(cnt2), .cfg_err(err2));

    typedef struct {
        logic       rst_n;
        logic       load;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       vld;
        logic       din;
        logic       exp_y;
        logic       exp_err;
        int         exp_c8;
        int         exp_c2;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   m8       = 0;
    int   m2       = 0;
    logic cur_err  = 1'b1;

    task automatic push(input logic rst_n, input logic load, input logic [7:0] pat,
                        input logic [3:0] len, input logic ovl, input logic vld,
                        input logic d, input logic exp_y, input logic exp_err);
        vec_t v;
        if (!rst_n) begin
            m8 = 0;
            m2 = 0;
        end else if (exp_y) begin
            if (m8 < 255) m8++;
            if (m2 < 3) m2++;
        end
        v.rst_n = rst_n; v.load = load; v.pat = pat; v.len = len; v.ovl = ovl;
        v.vld = vld; v.din = d; v.exp_y = exp_y; v.exp_err = exp_err;
        v.exp_c8 = m8; v.exp_c2 = m2;
        vecs.push_back(v);
    endtask

    task automatic p_rst();
        cur_err = 1'b1;
        push(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic p_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic err);
        cur_err = err;
        push(1'b1, 1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, err);
    endtask

    task automatic p_bit(input logic d, input logic exp_y);
        push(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, d, exp_y, cur_err);
    endtask

    task automatic p_gap(input logic d);
        push(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, d, 1'b0, cur_err);
    endtask

    // bits[i] / ys[i] are the i-th bit in time and whether y must fire on it.
    task automatic p_bits(input logic [15:0] bits, input int n, input logic [15:0] ys);
        for (int i = 0; i < n; i++) p_bit(bits[i], ys[i]);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

        // reset state, y held low even with a valid 1 on the line
        p_rst();
        p_rst();

        // 101, overlapping then non-overlapping
        p_cfg(8'b101, 4'd3, 1'b1, 1'b0);
        p_bits(16'b10101001010, 11, 16'b10100001000);
        p_cfg(8'b101, 4'd3, 1'b0, 1'b0);
        p_bits(16'b10101001010, 11, 16'b00100001000);

        // 1011, overlapping then non-overlapping
        p_cfg(8'b1011, 4'd4, 1'b1, 1'b0);
        p_bits(16'b1101101, 7, 16'b1001000);
        p_cfg(8'b1011, 4'd4, 1'b0, 1'b0);
        p_bits(16'b1101101, 7, 16'b0001000);

        // valid gaps between pattern bits
        p_cfg(8'b101, 4'd3, 1'b1, 1'b0);
        p_bit(1'b1, 1'b0);
        p_gap(1'b1);
        p_gap(1'b0);
        p_bit(1'b0, 1'b0);
        p_gap(1'b1);
        p_bit(1'b1, 1'b1);

        // invalid lengths suppress y
        p_cfg(8'hFF, 4'd0, 1'b1, 1'b1);
        p_bits(16'b111, 3, 16'b0);
        p_cfg(8'h00, 4'd9, 1'b1, 1'b1);
        p_bits(16'b000, 3, 16'b0);

        // load with a simultaneous valid bit: bit discarded, y low
        cur_err = 1'b0;
        push(1'b1, 1'b1, 8'b11, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        p_bit(1'b1, 1'b0);
        p_bit(1'b1, 1'b1);
        p_bit(1'b1, 1'b1);

        // full-length pattern with fill saturation and overlap on suffix 101
        p_cfg(8'hA5, 4'd8, 1'b1, 1'b0);
        p_bits(16'b1010010100101, 13, 16'b1000010000000);

        // len=1 and 2-bit counter saturation
        p_rst();
        p_cfg(8'h01, 4'd1, 1'b1, 1'b0);
        p_bits(16'b111111, 6, 16'b111111);
        p_bit(1'b0, 1'b0);

        // reset mid-pattern discards history
        p_cfg(8'b101, 4'd3, 1'b1, 1'b0);
        p_bit(1'b1, 1'b0);
        p_bit(1'b0, 1'b0);
        p_rst();
        p_bit(1'b1, 1'b0);
        p_cfg(8'b101, 4'd3, 1'b1, 1'b0);
        p_bit(1'b1, 1'b0);
        p_bit(1'b0, 1'b0);
        p_bit(1'b1, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset       = vecs[i].rst_n;
            cfg_load    = vecs[i].load;
            cfg_pattern = vecs[i].pat;
            cfg_len     = vecs[i].len;
            cfg_overlap = vecs[i].ovl;
            din_valid   = vecs[i].vld;
            din         = vecs[i].din;
            #1;
            chk("y8", i, 32'(y8), 32'(vecs[i].exp_y));
            chk("y2", i, 32'(y2), 32'(vecs[i].exp_y));
            @(posedge clk);
            #1;
            chk("cfg_err", i, 32'(err8), 32'(vecs[i].exp_err));
            chk("cfg_err2", i, 32'(err2), 32'(vecs[i].exp_err));
            chk("count8", i, 32'(cnt8), 32'(vecs[i].exp_c8));
            chk("count2", i, 32'(cnt2), 32'(vecs[i].exp_c2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
